// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing pipe: default 640x480 timing,
// phase enums, background palette, counter-width helper and the payload
// that travels down the alignment delay line.
package vga_pkg;

    localparam int unsigned DEF_COLOR_W  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIPE     = 1;
    localparam int unsigned DEF_BG_ROW1  = 240;
    localparam int unsigned DEF_BG_ROW2  = 264;

    localparam logic [5:0] DEF_BG_C0 = 6'b001111;
    localparam logic [5:0] DEF_BG_C1 = 6'b001100;
    localparam logic [5:0] DEF_BG_C2 = 6'b001000;

    typedef enum logic [1:0] {HP_ACT, HP_FP, HP_SYNC, HP_BP} h_phase_t;
    typedef enum logic [1:0] {VP_ACT, VP_FP, VP_SYNC, VP_BP} v_phase_t;
    typedef enum logic [1:0] {BAND_0, BAND_1, BAND_2} bg_band_t;

    // Per-pixel attributes that must be delayed to meet rgb_in/draw.
    typedef struct packed {
        logic     act;
        logic     hs;    // hsync window, asserted-high internally
        logic     vs;    // vsync window, asserted-high internally
        bg_band_t band;
        logic     fs;
        logic     ls;
    } align_t;

    // Counter width: wide enough for the larger of the two totals.
    function automatic int unsigned count_width(input int unsigned h_total,
                                                input int unsigned v_total);
        int unsigned t;
        t = (h_total > v_total) ? h_total : v_total;
        return (t <= 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align sync/blank attributes with
// the pixel source latency. DEPTH=0 is a plain wire.
//   clk, rst_n : clock, async active-low reset (clears all stages)
//   en         : advance enable
//   d / q      : WIDTH-bit input / DEPTH-cycle delayed output
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, en};
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        // Stage 0 takes d; each later stage takes its predecessor.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator and pixel output stage. Counters feed
// the renderers; sync/blank/band/strobe attributes are delayed PIPE enabled
// cycles to meet rgb_in/draw, then everything is registered to the pins.
//   clk, rst_n, en          : clock, async active-low reset, pixel enable
//   rgb_in, draw            : sprite colour {R,G,B} and opaque flag
//   hor_count, ver_count    : current column / line
//   red/green/blue_out      : DAC colour
//   hsync, vsync            : syncs, asserted level SYNC_POL
//   active                  : visible-region flag at the pins
//   frame_start, line_start : pin-aligned strobes at (0,0) / column 0
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned PIPE     = DEF_PIPE,
    parameter int unsigned BG_ROW1  = DEF_BG_ROW1,
    parameter int unsigned BG_ROW2  = DEF_BG_ROW2,
    parameter logic [3*COLOR_W-1:0] BG_C0 = (3*COLOR_W)'(DEF_BG_C0),
    parameter logic [3*COLOR_W-1:0] BG_C1 = (3*COLOR_W)'(DEF_BG_C1),
    parameter logic [3*COLOR_W-1:0] BG_C2 = (3*COLOR_W)'(DEF_BG_C2),
    localparam int unsigned CW = count_width(H_ACTIVE + H_FP + H_SYNC + H_BP,
                                             V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [3*COLOR_W-1:0] rgb_in,
    input  logic                 draw,
    output logic [CW-1:0]        hor_count,
    output logic [CW-1:0]        ver_count,
    output logic [COLOR_W-1:0]   red_out,
    output logic [COLOR_W-1:0]   green_out,
    output logic [COLOR_W-1:0]   blue_out,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 active,
    output logic                 frame_start,
    output logic                 line_start
);

    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CD = 3 * COLOR_W;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    // Parameter sanity checks at elaboration.
    if (COLOR_W == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_pipe: timing parameters must be non-zero");
    end
    if (PIPE > 7) begin : g_bad_pipe
        $error("vga_timing_pipe: PIPE must be 0..7");
    end
    if (BG_ROW1 > BG_ROW2) begin : g_bad_rows
        $error("vga_timing_pipe: BG_ROW1 must not exceed BG_ROW2");
    end

    h_phase_t      h_phase;
    v_phase_t      v_phase;
    align_t        cur;
    align_t        dly;
    logic [CD-1:0] pix;

    // Raster counters; both wrap on the same edge at the end of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hor_count <= '0;
            ver_count <= '0;
        end else if (en) begin
            if (hor_count == CW'(HT - 1)) begin
                hor_count <= '0;
                if (ver_count == CW'(VT - 1)) ver_count <= '0;
                else                          ver_count <= ver_count + CW'(1);
            end else begin
                hor_count <= hor_count + CW'(1);
            end
        end
    end

    // Phase decode from the current coordinates.
    always_comb begin
        h_phase = HP_ACT;
        if (32'(hor_count) >= H_ACTIVE + H_FP + H_SYNC) h_phase = HP_BP;
        else if (32'(hor_count) >= H_ACTIVE + H_FP)     h_phase = HP_SYNC;
        else if (32'(hor_count) >= H_ACTIVE)            h_phase = HP_FP;

        v_phase = VP_ACT;
        if (32'(ver_count) >= V_ACTIVE + V_FP + V_SYNC) v_phase = VP_BP;
        else if (32'(ver_count) >= V_ACTIVE + V_FP)     v_phase = VP_SYNC;
        else if (32'(ver_count) >= V_ACTIVE)            v_phase = VP_FP;
    end

    // Attributes of the current coordinate, before alignment.
    always_comb begin
        cur      = '0;
        cur.act  = (h_phase == HP_ACT) && (v_phase == VP_ACT);
        cur.hs   = (h_phase == HP_SYNC);
        cur.vs   = (v_phase == VP_SYNC);
        cur.band = BAND_2;
        if (32'(ver_count) < BG_ROW1)      cur.band = BAND_0;
        else if (32'(ver_count) < BG_ROW2) cur.band = BAND_1;
        cur.fs   = (hor_count == '0) && (ver_count == '0);
        cur.ls   = (hor_count == '0);
    end

    vga_delay_line #(
        .WIDTH ($bits(align_t)),
        .DEPTH (PIPE)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (cur),
        .q     (dly)
    );

    // Colour select: blank, sprite, or background band.
    always_comb begin
        pix = '0;
        if (dly.act) begin
            if (draw) begin
                pix = rgb_in;
            end else begin
                case (dly.band)
                    BAND_0:  pix = BG_C0;
                    BAND_1:  pix = BG_C1;
                    default: pix = BG_C2;
                endcase
            end
        end
    end

    // Pin register; the only delay stage when PIPE=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            active      <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (en) begin
            {red_out, green_out, blue_out} <= pix;
            hsync       <= dly.hs ? SYNC_ON : ~SYNC_ON;
            vsync       <= dly.vs ? SYNC_ON : ~SYNC_ON;
            active      <= dly.act;
            frame_start <= dly.fs;
            line_start  <= dly.ls;
        end
    end

endmodule
